// File: rtl/int_ctrl_8051.sv
// int_ctrl_8051: 8051 interrupt controller with IE/IP SFRs, priority arbitration and in-service tracking.
// Build option: define INT_CTRL_PRIORITY_EN for the IP register and two-level (high-over-low) nesting.
module int_ctrl_8051 #(
    parameter int NSRC = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            set_IE,
    input  logic            set_IP,
    input  logic [7:0]      ram_rd_byte,
    input  logic [NSRC-1:0] int_src,
    input  logic            int_ack,
    input  logic            reti,
    output logic            irq_req,
    output logic [15:0]     vector_addr,
    output logic [NSRC-1:0] src_clr,
    output logic [7:0]      ie_out,
    output logic [7:0]      ip_out
);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [NSRC-1:0] ONE_HOT0 = {{(NSRC-1){1'b0}}, 1'b1};
    // The last source (serial RI|TI) must be cleared by software, never by hardware.
    localparam logic [NSRC-1:0] CLR_MASK = {1'b0, {(NSRC-1){1'b1}}};

    logic [7:0]      r_ie;
    logic [NSRC-1:0] r_src;
    logic            r_isLo;
    logic            r_isHi;
    logic            r_irq;
    logic [15:0]     r_vector;
    logic [IW-1:0]   r_winIdx;
    logic            r_winHi;
    logic [NSRC-1:0] r_clrPend;
    logic [NSRC-1:0] r_clr;

    logic [NSRC-1:0] w_ip;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_hiReq;
    logic [NSRC-1:0] w_loReq;
    logic [IW-1:0]   w_hiIdx;
    logic [IW-1:0]   w_loIdx;
    logic [IW-1:0]   w_winIdx;
    logic            w_winHi;
    logic            w_winOk;
    logic [15:0]     w_winVec;
    logic            w_holdOff;
    logic            w_irqNext;
    logic            w_ackOk;
    logic            w_isLoNext;
    logic            w_isHiNext;

`ifdef INT_CTRL_PRIORITY_EN
    logic [NSRC-1:0] r_ip;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ip <= '0;
        end else if (set_IP) begin
            r_ip <= ram_rd_byte[NSRC-1:0];
        end
    end

    assign w_ip   = r_ip;
    assign ip_out = 8'(r_ip);
`else
    // Without IP every source sits on the single (low) level.
    assign w_ip   = '0;
    assign ip_out = 8'h00;
`endif

    assign w_elig  = r_src & r_ie[NSRC-1:0] & {NSRC{r_ie[7]}};
    assign w_hiReq = w_elig & w_ip;
    assign w_loReq = w_elig & ~w_ip;

    always_comb begin
        w_hiIdx  = '0;
        w_loIdx  = '0;
        w_winIdx = '0;
        w_winHi  = 1'b0;
        w_winOk  = 1'b0;
        // Descending scan so the lowest set index is the last one written.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_hiReq[i]) w_hiIdx = IW'(i);
            if (w_loReq[i]) w_loIdx = IW'(i);
        end
        if (|w_hiReq) begin
            w_winIdx = w_hiIdx;
            w_winHi  = 1'b1;
            w_winOk  = !r_isHi;
        end else begin
            w_winIdx = w_loIdx;
            w_winHi  = 1'b0;
            w_winOk  = (|w_loReq) && !r_isHi && !r_isLo;
        end
    end

    assign w_winVec  = 16'({w_winIdx, 3'b011});
    assign w_holdOff = set_IE | set_IP | reti;
    assign w_irqNext = w_winOk & ~w_holdOff;
    assign w_ackOk   = int_ack & r_irq;

    always_comb begin
        w_isLoNext = r_isLo;
        w_isHiNext = r_isHi;
        // RETI unwinds the innermost level before a coincident ack records the new one.
        if (reti) begin
            if (r_isHi) w_isHiNext = 1'b0;
            else        w_isLoNext = 1'b0;
        end
        if (w_ackOk) begin
            if (r_winHi) w_isHiNext = 1'b1;
            else         w_isLoNext = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ie      <= 8'h00;
            r_src     <= '0;
            r_isLo    <= 1'b0;
            r_isHi    <= 1'b0;
            r_irq     <= 1'b0;
            r_vector  <= 16'h0000;
            r_winIdx  <= '0;
            r_winHi   <= 1'b0;
            r_clrPend <= '0;
            r_clr     <= '0;
        end else begin
            if (set_IE) r_ie <= ram_rd_byte;
            r_src  <= int_src;
            r_isLo <= w_isLoNext;
            r_isHi <= w_isHiNext;
            r_irq  <= w_irqNext;
            if (w_irqNext) begin
                r_vector <= w_winVec;
                r_winIdx <= w_winIdx;
                r_winHi  <= w_winHi;
            end
            r_clrPend <= w_ackOk ? ((ONE_HOT0 << r_winIdx) & CLR_MASK) : '0;
            r_clr     <= r_clrPend;
        end
    end

    assign irq_req     = r_irq;
    assign vector_addr = r_vector;
    assign src_clr     = r_clr;
    assign ie_out      = r_ie;

endmodule

// File: tb/tb_int_ctrl_8051.sv
// tb_int_ctrl_8051: scoreboard bench for int_ctrl_8051; expectations are queued with a target edge.
// Scenarios adapt to the INT_CTRL_PRIORITY_EN build option.
module tb_int_ctrl_8051;
    localparam int K_IRQ = 0;
    localparam int K_VEC = 1;
    localparam int K_CLR = 2;
    localparam int K_IE  = 3;
    localparam int K_IP  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        set_IE;
    logic        set_IP;
    logic [7:0]  ram_rd_byte;
    logic [4:0]  int_src;
    logic        int_ack;
    logic        reti;
    logic        irq_req;
    logic [15:0] vector_addr;
    logic [4:0]  src_clr;
    logic [7:0]  ie_out;
    logic [7:0]  ip_out;

    typedef struct {
        int          cyc;
        string       tag;
        int          kind;
        logic [15:0] value;
    } expect_t;

    expect_t sb[$];
    int vectors     = 0;
    int miscompares = 0;
    int edgeCnt     = 0;

    int_ctrl_8051 #(.NSRC(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .set_IE      (set_IE),
        .set_IP      (set_IP),
        .ram_rd_byte (ram_rd_byte),
        .int_src     (int_src),
        .int_ack     (int_ack),
        .reti        (reti),
        .irq_req     (irq_req),
        .vector_addr (vector_addr),
        .src_clr     (src_clr),
        .ie_out      (ie_out),
        .ip_out      (ip_out)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            K_IRQ:   return {15'h0, irq_req};
            K_VEC:   return vector_addr;
            K_CLR:   return {11'h0, src_clr};
            K_IE:    return {8'h0, ie_out};
            default: return {8'h0, ip_out};
        endcase
    endfunction

    // Queue an expectation for the value seen after the edge 'delay' edges from now.
    task automatic expectOut(input int delay, input string tag, input int kind, input logic [15:0] value);
        expect_t e;
        e.cyc   = edgeCnt + delay;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        sb.push_back(e);
    endtask

    // One clock: outputs are compared on the falling edge, then the sources drop flags that were cleared.
    task automatic tick();
        int idx;
        @(posedge clock);
        edgeCnt++;
        @(negedge clock);
        idx = 0;
        while (idx < sb.size()) begin
            if (sb[idx].cyc == edgeCnt) begin
                checkOutput(sb[idx].tag, observe(sb[idx].kind), sb[idx].value);
                sb.delete(idx);
            end else begin
                idx++;
            end
        end
        int_src = int_src & ~src_clr;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic setIe, input logic setIp, input logic [7:0] data,
                                 input logic ack, input logic rt);
        set_IE      = setIe;
        set_IP      = setIp;
        ram_rd_byte = data;
        int_ack     = ack;
        reti        = rt;
        tick();
        set_IE      = 1'b0;
        set_IP      = 1'b0;
        ram_rd_byte = 8'h00;
        int_ack     = 1'b0;
        reti        = 1'b0;
    endtask

    task automatic expectResetValues(input string tag);
        expectOut(1, {tag, " irq"}, K_IRQ, 16'h0);
        expectOut(1, {tag, " vec"}, K_VEC, 16'h0);
        expectOut(1, {tag, " clr"}, K_CLR, 16'h0);
        expectOut(1, {tag, " ie"},  K_IE,  16'h0);
        expectOut(1, {tag, " ip"},  K_IP,  16'h0);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        int_src = 5'b0;
        expectResetValues("reset");
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; set_IE = 1'b0; set_IP = 1'b0; ram_rd_byte = 8'h00;
        int_src = 5'b0; int_ack = 1'b0; reti = 1'b0;
        @(negedge clock);

        // Basic TF0 request, ack and hardware flag clear
        doReset();
        int_src = 5'b00010;
        expectOut(1, "s1 ie", K_IE, 16'h0082);
        expectOut(1, "s1 holdoff", K_IRQ, 16'h0);
        expectOut(2, "s1 irq", K_IRQ, 16'h1);
        expectOut(2, "s1 vec", K_VEC, 16'h000B);
        applyStimulus(1, 0, 8'h82, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        expectOut(2, "s1 ackDrop", K_IRQ, 16'h0);
        expectOut(2, "s1 clr", K_CLR, 16'h0002);
        expectOut(3, "s1 clrEnd", K_CLR, 16'h0);
        expectOut(3, "s1 vecHold", K_VEC, 16'h000B);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(2);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // All sources at once: natural order, then blocked until RETI
        doReset();
        applyStimulus(1, 0, 8'h9F, 0, 0);
        expectOut(1, "s2 ip", K_IP, 16'h0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        int_src = 5'h1F;
        expectOut(1, "s2 latency", K_IRQ, 16'h0);
        expectOut(2, "s2 irq", K_IRQ, 16'h1);
        expectOut(2, "s2 vec", K_VEC, 16'h0003);
        idle(2);
        expectOut(2, "s2 ackDrop", K_IRQ, 16'h0);
        expectOut(2, "s2 clr", K_CLR, 16'h0001);
        expectOut(4, "s2 blocked", K_IRQ, 16'h0);
        expectOut(4, "s2 vecHold", K_VEC, 16'h0003);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(4);
        expectOut(1, "s2 retiHold", K_IRQ, 16'h0);
        expectOut(2, "s2 irq2", K_IRQ, 16'h1);
        expectOut(2, "s2 vec2", K_VEC, 16'h000B);
        applyStimulus(0, 0, 8'h00, 0, 1);
        idle(1);

        // Nesting: IE0 low in service, TF1 arrives
        doReset();
        applyStimulus(1, 0, 8'h9F, 0, 0);
`ifdef INT_CTRL_PRIORITY_EN
        expectOut(1, "s3 ip", K_IP, 16'h0008);
`else
        expectOut(1, "s3 ip", K_IP, 16'h0000);
`endif
        applyStimulus(0, 1, 8'h08, 0, 0);
        int_src = 5'b00001;
        expectOut(2, "s3 irqIe0", K_IRQ, 16'h1);
        expectOut(2, "s3 vecIe0", K_VEC, 16'h0003);
        idle(2);
        expectOut(2, "s3 clrIe0", K_CLR, 16'h0001);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(2);
        int_src[3] = 1'b1;
`ifdef INT_CTRL_PRIORITY_EN
        expectOut(2, "s3 preempt", K_IRQ, 16'h1);
        expectOut(2, "s3 vecTf1", K_VEC, 16'h001B);
        idle(2);
        expectOut(2, "s3 clrTf1", K_CLR, 16'h0008);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(1);
        int_src[0] = 1'b1;
        expectOut(3, "s3 ie0BlockedHi", K_IRQ, 16'h0);
        idle(3);
        expectOut(2, "s3 ie0BlockedLo", K_IRQ, 16'h0);
        applyStimulus(0, 0, 8'h00, 0, 1);
        idle(1);
        expectOut(1, "s3 retiHold", K_IRQ, 16'h0);
        expectOut(2, "s3 irqIe0Again", K_IRQ, 16'h1);
        expectOut(2, "s3 vecIe0Again", K_VEC, 16'h0003);
        applyStimulus(0, 0, 8'h00, 0, 1);
        idle(1);
`else
        expectOut(4, "s3 singleLevelBlock", K_IRQ, 16'h0);
        idle(4);
        expectOut(1, "s3 retiHold", K_IRQ, 16'h0);
        expectOut(2, "s3 irqTf1", K_IRQ, 16'h1);
        expectOut(2, "s3 vecTf1", K_VEC, 16'h001B);
        applyStimulus(0, 0, 8'h00, 0, 1);
        idle(1);
`endif

        // Serial source is never hardware-cleared; EA off masks everything
        doReset();
        int_src = 5'b10000;
        expectOut(2, "s4 irq", K_IRQ, 16'h1);
        expectOut(2, "s4 vec", K_VEC, 16'h0023);
        applyStimulus(1, 0, 8'h90, 0, 0);
        idle(1);
        expectOut(2, "s4 ackDrop", K_IRQ, 16'h0);
        expectOut(2, "s4 clrNone", K_CLR, 16'h0);
        expectOut(3, "s4 clrNone2", K_CLR, 16'h0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(2);
        expectOut(1, "s4 retiHold", K_IRQ, 16'h0);
        expectOut(2, "s4 irqAgain", K_IRQ, 16'h1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        idle(1);
        expectOut(1, "s4 ieNoEa", K_IE, 16'h0010);
        expectOut(1, "s4 eaHold", K_IRQ, 16'h0);
        expectOut(3, "s4 eaOff", K_IRQ, 16'h0);
        applyStimulus(1, 0, 8'h10, 0, 0);
        idle(2);
        int_src = 5'b0;

        // IE cleared while requesting; late ack ignored; IP write
        doReset();
        int_src = 5'b00010;
        expectOut(2, "s5 irq", K_IRQ, 16'h1);
        applyStimulus(1, 0, 8'h82, 0, 0);
        idle(1);
        expectOut(1, "s5 ieOffDrop", K_IRQ, 16'h0);
        applyStimulus(1, 0, 8'h00, 0, 0);
        expectOut(2, "s5 ackIgnoredClr", K_CLR, 16'h0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(1);
`ifdef INT_CTRL_PRIORITY_EN
        expectOut(1, "s5 ip", K_IP, 16'h001F);
`else
        expectOut(1, "s5 ip", K_IP, 16'h0000);
`endif
        applyStimulus(0, 1, 8'hFF, 0, 0);
        expectOut(1, "s5 ieOnHold", K_IRQ, 16'h0);
        expectOut(2, "s5 irqBack", K_IRQ, 16'h1);
        expectOut(2, "s5 vecBack", K_VEC, 16'h000B);
        applyStimulus(1, 0, 8'h82, 0, 0);
        idle(1);

        // Reset in the middle of service
        doReset();
        applyStimulus(1, 0, 8'h9F, 0, 0);
        applyStimulus(0, 1, 8'h08, 0, 0);
        int_src = 5'b00001;
        idle(2);
        applyStimulus(0, 0, 8'h00, 1, 0);
        idle(2);
        int_src[3] = 1'b1;
        idle(2);
        applyStimulus(0, 0, 8'h00, 1, 0);
        reset = 1'b1;
        expectResetValues("s6 midReset");
        tick();
        reset   = 1'b0;
        int_src = 5'b00010;
        expectOut(1, "s6 holdoff", K_IRQ, 16'h0);
        expectOut(2, "s6 irqBack", K_IRQ, 16'h1);
        expectOut(2, "s6 vecBack", K_VEC, 16'h000B);
        applyStimulus(1, 0, 8'h82, 0, 0);
        idle(3);

        checkOutput("sbDrained", 16'(sb.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
